// File: rtl/dpram_rr_arbiter_if.sv
// Requester-side bundle of the dual-port RAM arbiter: request handshake and read response.
interface dpram_rr_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int A_WIDTH = 3,
    parameter int D_WIDTH = 8
);
    logic [NREQ-1:0]               req_valid;
    logic [NREQ-1:0]               req_we;
    logic [NREQ-1:0][A_WIDTH-1:0]  req_addr;
    logic [NREQ-1:0][D_WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]               req_ready;
    logic [NREQ-1:0]               rsp_valid;
    logic [D_WIDTH-1:0]            rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NREQ requesters, with read-response routing.
// Optional statistics outputs are enabled by defining DPRAM_ARB_STATS_EN.
module dpram_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int A_WIDTH = 3,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    dpram_rr_arbiter_if.slave  bus,
    output logic               ram_we_a,
    output logic [A_WIDTH-1:0] ram_add_a,
    output logic [D_WIDTH-1:0] ram_din_a,
    output logic               ram_we_b,
    output logic [A_WIDTH-1:0] ram_add_b,
    output logic [D_WIDTH-1:0] ram_din_b,
    input  logic [D_WIDTH-1:0] ram_dout_a,
    input  logic [D_WIDTH-1:0] ram_dout_b
`ifdef DPRAM_ARB_STATS_EN
    ,
    output logic [15:0]        stat_conflict,
    output logic [31:0]        stat_grants
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_nxt;
    logic [NREQ-1:0]    elig;
    logic               read_block;
    logic               gnt_a_vld;
    logic               gnt_b_vld;
    logic [IW-1:0]      gnt_a;
    logic [IW-1:0]      gnt_b;
    logic               tag_a_vld;
    logic               tag_b_vld;
    logic [IW-1:0]      tag_a_idx;
    logic [IW-1:0]      tag_b_idx;
    logic               hold_vld;
    logic [IW-1:0]      hold_idx;
    logic [D_WIDTH-1:0] hold_data;
`ifdef DPRAM_ARB_STATS_EN
    logic               conf_evt;
`endif

    function automatic logic [IW-1:0] wrap_idx(input logic [31:0] base, input logic [31:0] off);
        logic [31:0] s;
        s = base + off;
        if (s >= 32'(NREQ))
            s = s - 32'(NREQ);
        return s[IW-1:0];
    endfunction

    // Two reads issued together occupy the response bus for two cycles, so no read
    // may be granted on either port while the port-B result is waiting for its slot.
    always_comb begin
        read_block = tag_a_vld & tag_b_vld;
        elig       = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            elig[i] = bus.req_valid[i] & ~rst & (bus.req_we[i] | ~read_block);
    end

    always_comb begin
        logic [IW-1:0] idx;
        logic          hit;
`ifdef DPRAM_ARB_STATS_EN
        logic          first_seen;
        first_seen = 1'b0;
        conf_evt   = 1'b0;
`endif
        idx       = '0;
        hit       = 1'b0;
        gnt_a_vld = 1'b0;
        gnt_a     = '0;
        gnt_b_vld = 1'b0;
        gnt_b     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = wrap_idx(32'(rr_ptr), k);
            if (!gnt_a_vld && elig[idx]) begin
                gnt_a_vld = 1'b1;
                gnt_a     = idx;
            end
        end
        if (gnt_a_vld) begin
            for (int unsigned k = 1; k < NREQ; k++) begin
                idx = wrap_idx(32'(gnt_a), k);
                if (!gnt_b_vld && elig[idx]) begin
                    hit = (bus.req_addr[idx] == bus.req_addr[gnt_a]) &&
                          (bus.req_we[idx] || bus.req_we[gnt_a]);
`ifdef DPRAM_ARB_STATS_EN
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        conf_evt   = hit;
                    end
`endif
                    if (!hit) begin
                        gnt_b_vld = 1'b1;
                        gnt_b     = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        rr_nxt = rr_ptr;
        if (gnt_b_vld)
            rr_nxt = wrap_idx(32'(gnt_b), 32'd1);
        else if (gnt_a_vld)
            rr_nxt = wrap_idx(32'(gnt_a), 32'd1);
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_a_vld)
            bus.req_ready[gnt_a] = 1'b1;
        if (gnt_b_vld)
            bus.req_ready[gnt_b] = 1'b1;
        ram_we_a  = gnt_a_vld & bus.req_we[gnt_a];
        ram_add_a = gnt_a_vld ? bus.req_addr[gnt_a]  : '0;
        ram_din_a = gnt_a_vld ? bus.req_wdata[gnt_a] : '0;
        ram_we_b  = gnt_b_vld & bus.req_we[gnt_b];
        ram_add_b = gnt_b_vld ? bus.req_addr[gnt_b]  : '0;
        ram_din_b = gnt_b_vld ? bus.req_wdata[gnt_b] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            tag_a_vld <= 1'b0;
            tag_a_idx <= '0;
            tag_b_vld <= 1'b0;
            tag_b_idx <= '0;
            hold_vld  <= 1'b0;
            hold_idx  <= '0;
            hold_data <= '0;
        end else begin
            rr_ptr    <= rr_nxt;
            tag_a_vld <= gnt_a_vld & ~bus.req_we[gnt_a];
            tag_a_idx <= gnt_a;
            tag_b_vld <= gnt_b_vld & ~bus.req_we[gnt_b];
            tag_b_idx <= gnt_b;
            hold_vld  <= read_block;
            hold_idx  <= tag_b_idx;
            if (read_block)
                hold_data <= ram_dout_b;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        if (tag_a_vld) begin
            bus.rsp_valid[tag_a_idx] = 1'b1;
            bus.rsp_rdata            = ram_dout_a;
        end else if (tag_b_vld) begin
            bus.rsp_valid[tag_b_idx] = 1'b1;
            bus.rsp_rdata            = ram_dout_b;
        end else if (hold_vld) begin
            bus.rsp_valid[hold_idx]  = 1'b1;
            bus.rsp_rdata            = hold_data;
        end
    end

`ifdef DPRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflict <= '0;
            stat_grants   <= '0;
        end else begin
            if (conf_evt && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
            stat_grants <= stat_grants + 32'(gnt_a_vld) + 32'(gnt_b_vld);
        end
    end
`endif

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Self-checking bench for dpram_rr_arbiter with a read-first dual-port RAM model and a response scoreboard.
module tb_dpram_rr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_rr_arbiter_if #(.NREQ(NREQ), .A_WIDTH(AW), .D_WIDTH(DW)) bus ();

    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_add_a, ram_add_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;
`ifdef DPRAM_ARB_STATS_EN
    logic [15:0]   stat_conflict;
    logic [31:0]   stat_grants;
`endif

    dpram_rr_arbiter #(.NREQ(NREQ), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_we_a(ram_we_a), .ram_add_a(ram_add_a), .ram_din_a(ram_din_a),
        .ram_we_b(ram_we_b), .ram_add_b(ram_add_b), .ram_din_b(ram_din_b),
        .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
`ifdef DPRAM_ARB_STATS_EN
        , .stat_conflict(stat_conflict), .stat_grants(stat_grants)
`endif
    );

    // Read-first synchronous dual-port RAM, one cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ram_dout_a = '0;
        ram_dout_b = '0;
    end
    always @(posedge clk) begin
        ram_dout_a <= mem[ram_add_a];
        ram_dout_b <= mem[ram_add_b];
        if (ram_we_a) mem[ram_add_a] <= ram_din_a;
        if (ram_we_b) mem[ram_add_b] <= ram_din_b;
    end

    typedef struct {
        int unsigned cyc;
        int unsigned idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    int unsigned cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] exp_v;
        logic [DW-1:0]   exp_d;
        exp_v = '0;
        exp_d = '0;
        for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                exp_v[sbq[i].idx] = 1'b1;
                exp_d = sbq[i].data;
                sbq.delete(i);
            end
        end
        total++;
        if (bus.rsp_valid !== exp_v)
            $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, bus.rsp_valid, exp_v);
        else passed++;
        if (exp_v != '0) begin
            total++;
            if (bus.rsp_rdata !== exp_d)
                $display("FAIL rsp_rdata cyc=%0d: got %h expected %h", cyc, bus.rsp_rdata, exp_d);
            else passed++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int unsigned i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_we[i]    = we;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
    endtask

    task automatic push_exp(input int unsigned c, input int unsigned idx, input logic [DW-1:0] d);
        sbq.push_back('{c, idx, d});
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        clear_reqs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_we    = '1;
        #1;
        total++;
        if (bus.req_ready !== 4'b0000) $display("FAIL rst_ready: got %b expected 0000", bus.req_ready);
        else passed++;
        total++;
        if ({ram_we_a, ram_we_b} !== 2'b00) $display("FAIL rst_we: got %b expected 00", {ram_we_a, ram_we_b});
        else passed++;
        total++;
        if (bus.rsp_rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", bus.rsp_rdata);
        else passed++;
        tick();
        clear_reqs();
        rst = 1'b0;
        tick();
        total++;
        if (bus.req_ready !== 4'b0000 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0)
            $display("FAIL idle_after_rst: got ready=%b we=%b%b expected 0000 00",
                     bus.req_ready, ram_we_a, ram_we_b);
        else passed++;
    endtask

    task automatic test_write_pair();
        reset_pulse();
        set_req(0, 1'b1, 3'd2, 8'hA5);
        set_req(1, 1'b1, 3'd3, 8'h5A);
        #1;
        total++;
        if (bus.req_ready !== 4'b0011) $display("FAIL wp_ready: got %b expected 0011", bus.req_ready);
        else passed++;
        total++;
        if ({ram_we_a, ram_add_a, ram_din_a} !== {1'b1, 3'd2, 8'hA5})
            $display("FAIL wp_port_a: got we=%b add=%0d din=%h expected 1 2 a5", ram_we_a, ram_add_a, ram_din_a);
        else passed++;
        total++;
        if ({ram_we_b, ram_add_b, ram_din_b} !== {1'b1, 3'd3, 8'h5A})
            $display("FAIL wp_port_b: got we=%b add=%0d din=%h expected 1 3 5a", ram_we_b, ram_add_b, ram_din_b);
        else passed++;
        tick();
        clear_reqs();
        // rr_ptr is now 2: req2 wins port A, req0 follows on port B
        set_req(2, 1'b0, 3'd3, 8'h00);
        set_req(0, 1'b0, 3'd2, 8'h00);
        #1;
        total++;
        if (bus.req_ready !== 4'b0101 || ram_add_a !== 3'd3 || ram_add_b !== 3'd2)
            $display("FAIL rd_after_wr: got ready=%b add_a=%0d add_b=%0d expected 0101 3 2",
                     bus.req_ready, ram_add_a, ram_add_b);
        else passed++;
        push_exp(cyc + 1, 2, 8'h5A);
        push_exp(cyc + 2, 0, 8'hA5);
        tick();
        clear_reqs();
        repeat (3) tick();
    endtask

    task automatic test_conflict();
        reset_pulse();
        set_req(0, 1'b1, 3'd5, 8'h77);
        set_req(1, 1'b0, 3'd5, 8'h00);
        #1;
        total++;
        if (bus.req_ready !== 4'b0001 || ram_we_b !== 1'b0 || ram_add_b !== 3'd0)
            $display("FAIL conf_block: got ready=%b we_b=%b add_b=%0d expected 0001 0 0",
                     bus.req_ready, ram_we_b, ram_add_b);
        else passed++;
        tick();
        bus.req_valid[0] = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 4'b0010) $display("FAIL conf_next: got %b expected 0010", bus.req_ready);
        else passed++;
        push_exp(cyc + 1, 1, 8'h77);
        tick();
        clear_reqs();
        repeat (2) tick();
`ifdef DPRAM_ARB_STATS_EN
        total++;
        if (stat_conflict !== 16'd1) $display("FAIL stat_conflict: got %0d expected 1", stat_conflict);
        else passed++;
        total++;
        if (stat_grants !== 32'd2) $display("FAIL stat_grants: got %0d expected 2", stat_grants);
        else passed++;
`endif
    endtask

    task automatic test_rotation();
        logic [NREQ-1:0] wr_pat [4];
        logic [NREQ-1:0] rd_pat [4];
        wr_pat = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        rd_pat = '{4'b0011, 4'b0000, 4'b1100, 4'b0000};
        reset_pulse();
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'(i), 8'h10 + 8'(i));
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (bus.req_ready !== wr_pat[c])
                $display("FAIL rot_wr_c%0d: got %b expected %b", c, bus.req_ready, wr_pat[c]);
            else passed++;
            tick();
        end
        // Continuous reads: each dual read occupies the response bus for two cycles
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'(i), 8'h00);
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (bus.req_ready !== rd_pat[c])
                $display("FAIL rot_rd_c%0d: got %b expected %b", c, bus.req_ready, rd_pat[c]);
            else passed++;
            if (c == 0) begin
                push_exp(cyc + 1, 0, 8'h10);
                push_exp(cyc + 2, 1, 8'h11);
            end else if (c == 2) begin
                push_exp(cyc + 1, 2, 8'h12);
                push_exp(cyc + 2, 3, 8'h13);
            end
            tick();
        end
        clear_reqs();
        repeat (3) tick();
    endtask

    task automatic test_same_addr_reads();
        reset_pulse();
        set_req(0, 1'b1, 3'd7, 8'h3C);
        tick();
        reset_pulse();
        set_req(0, 1'b0, 3'd7, 8'h00);
        set_req(1, 1'b0, 3'd7, 8'h00);
        #1;
        total++;
        if (bus.req_ready !== 4'b0011 || ram_add_a !== 3'd7 || ram_add_b !== 3'd7)
            $display("FAIL rr_same: got ready=%b add_a=%0d add_b=%0d expected 0011 7 7",
                     bus.req_ready, ram_add_a, ram_add_b);
        else passed++;
        push_exp(cyc + 1, 0, 8'h3C);
        push_exp(cyc + 2, 1, 8'h3C);
        tick();
        clear_reqs();
        set_req(2, 1'b0, 3'd7, 8'h00);
        #1;
        total++;
        if (bus.req_ready !== 4'b0000) $display("FAIL rr_block: got %b expected 0000", bus.req_ready);
        else passed++;
        tick();
        total++;
        if (bus.req_ready !== 4'b0100) $display("FAIL rr_unblock: got %b expected 0100", bus.req_ready);
        else passed++;
        push_exp(cyc + 1, 2, 8'h3C);
        tick();
        clear_reqs();
        repeat (2) tick();
    endtask

    task automatic test_reset_drop();
        reset_pulse();
        set_req(2, 1'b0, 3'd7, 8'h00);
        #1;
        total++;
        if (bus.req_ready !== 4'b0100) $display("FAIL drop_grant: got %b expected 0100", bus.req_ready);
        else passed++;
        tick();
        rst = 1'b1;
        clear_reqs();
        tick();
        tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'(i + 4), 8'hC0 + 8'(i));
        #1;
        total++;
        if (bus.req_ready !== 4'b0011) $display("FAIL drop_ptr: got %b expected 0011", bus.req_ready);
        else passed++;
        tick();
        clear_reqs();
        repeat (2) tick();
    endtask

    initial begin
        clear_reqs();
        tick();
        test_reset();
        test_write_pair();
        test_conflict();
        test_rotation();
        test_same_addr_reads();
        test_reset_drop();
        repeat (3) tick();
        total++;
        if (sbq.size() != 0) $display("FAIL sb_empty: got %0d pending expected 0", sbq.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
